// File: rtl/join_pkg.sv
// Shared definitions for the stream-R join pipeline scheduler: FSM encoding and
// small helpers for valid-flag indexing and drain length.
package join_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StProbe,
    StDrain,
    StClear,
    StWaitEmpty
  } state_e;

  // Tuples carry their valid flag in the most significant bit.
  function automatic int unsigned valid_idx(input int unsigned width);
    return width - 1;
  endfunction

  // DRAIN_CYCLES = 2*STAGE_NUMS: long enough for the last window tuple to pass every stage.
  function automatic int unsigned drain_cycles(input int unsigned stages);
    return 2 * stages;
  endfunction

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry skid FIFO for pipeline results; exposes current and next occupancy so the
// owner can register a pause request one cycle ahead.
module result_skid_fifo #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       occupancy,
  output logic [1:0]       occupancy_next,
  output logic             dropped
);

  logic [WIDTH-1:0] mem0_q, mem1_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             pop_ok, push_ok;

  assign pop_ok    = pop & (count_q != 2'd0);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok   = push & ((count_q != 2'd2) | pop_ok);
  assign dropped   = push & ~push_ok;
  assign occupancy = count_q;
  assign pop_data  = (count_q == 2'd0) ? '0 : (rd_ptr_q ? mem1_q : mem0_q);

  always_comb begin
    occupancy_next = count_q;
    if (push_ok && !pop_ok) begin
      occupancy_next = count_q + 2'd1;
    end else if (pop_ok && !push_ok) begin
      occupancy_next = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok && !wr_ptr_q) mem0_q <= push_data;
      if (push_ok && wr_ptr_q)  mem1_q <= push_data;
      if (push_ok) wr_ptr_q <= ~wr_ptr_q;
      if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= occupancy_next;
    end
  end

endmodule

// File: rtl/join_pipeline_scheduler.sv
// Batch sequencer for the join pipeline: load stream tuples, probe with window tuples,
// drain, clear; also turns the pipeline result tail into a valid/ready stream.
module join_pipeline_scheduler
  import join_pkg::*;
#(
  parameter int unsigned WINDOW_TUPLE_WIDTH = 64,
  parameter int unsigned STREAM_TUPLE_WIDTH = 64,
  parameter int unsigned RESULT_PAIR_WIDTH  = 64,
  parameter int unsigned STAGE_NUMS         = 8,
  parameter int unsigned WLEN_WIDTH         = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          start,
  input  logic [WLEN_WIDTH-1:0]         window_len,
  output logic                          busy,
  output logic                          done,
  input  logic                          s_stream_valid,
  output logic                          s_stream_ready,
  input  logic                          s_stream_last,
  input  logic [STREAM_TUPLE_WIDTH-1:0] s_stream_data,
  input  logic                          s_window_valid,
  output logic                          s_window_ready,
  input  logic [WINDOW_TUPLE_WIDTH-1:0] s_window_data,
  input  logic                          pipe_stream_full,
  output logic                          pipe_stream_clear,
  output logic [STREAM_TUPLE_WIDTH-1:0] pipe_stream_tuple,
  input  logic                          pipe_window_full,
  output logic [WINDOW_TUPLE_WIDTH-1:0] pipe_window_tuple,
  input  logic [RESULT_PAIR_WIDTH-1:0]  pipe_result,
  output logic                          pipe_result_feedback,
  output logic                          m_result_valid,
  input  logic                          m_result_ready,
  output logic [RESULT_PAIR_WIDTH-1:0]  m_result_data,
  output logic                          err_overflow
);

  localparam int unsigned DrainCycles = drain_cycles(STAGE_NUMS);
  localparam int unsigned LoadW       = $clog2(STAGE_NUMS + 1);
  localparam int unsigned DrainW      = $clog2(DrainCycles + 1);
  localparam int unsigned ResultValid = valid_idx(RESULT_PAIR_WIDTH);

  state_e                state_q, state_d;
  logic [WLEN_WIDTH-1:0] win_len_q, win_len_d;
  logic [WLEN_WIDTH-1:0] win_cnt_q, win_cnt_d;
  logic [LoadW-1:0]      load_cnt_q, load_cnt_d;
  logic [DrainW-1:0]     drain_cnt_q, drain_cnt_d;
  logic                  stream_hs, window_hs;

  logic       result_push, result_pop, result_drop;
  logic [1:0] result_occ, result_occ_next;
  logic       feedback_d, err_overflow_d;

  assign busy      = (state_q != StIdle);
  assign stream_hs = s_stream_valid & ~pipe_stream_full;
  assign window_hs = s_window_valid & ~pipe_window_full & ~pipe_result_feedback;

  always_comb begin
    state_d           = state_q;
    win_len_d         = win_len_q;
    win_cnt_d         = win_cnt_q;
    load_cnt_d        = load_cnt_q;
    drain_cnt_d       = drain_cnt_q;
    s_stream_ready    = 1'b0;
    s_window_ready    = 1'b0;
    pipe_stream_tuple = '0;
    pipe_window_tuple = '0;
    pipe_stream_clear = 1'b0;
    done              = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          win_len_d   = window_len;
          win_cnt_d   = '0;
          load_cnt_d  = '0;
          drain_cnt_d = '0;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        s_stream_ready = ~pipe_stream_full;
        if (stream_hs) begin
          pipe_stream_tuple = s_stream_data;
          load_cnt_d        = load_cnt_q + 1'b1;
          if (load_cnt_d == LoadW'(STAGE_NUMS) || s_stream_last) state_d = StProbe;
        end
      end
      StProbe: begin
        // Also covers window_len == 0: nothing is offered, straight to drain.
        if (win_cnt_q == win_len_q) begin
          state_d = StDrain;
        end else begin
          s_window_ready = ~pipe_window_full & ~pipe_result_feedback;
          if (window_hs) begin
            pipe_window_tuple = s_window_data;
            win_cnt_d         = win_cnt_q + 1'b1;
            if (win_cnt_d == win_len_q) state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!pipe_result_feedback) begin
          drain_cnt_d = drain_cnt_q + 1'b1;
          if (drain_cnt_d == DrainW'(DrainCycles)) state_d = StClear;
        end
      end
      StClear: begin
        pipe_stream_clear = 1'b1;
        state_d           = StWaitEmpty;
      end
      StWaitEmpty: begin
        if (!pipe_stream_full) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign result_push    = pipe_result[ResultValid];
  assign m_result_valid = (result_occ != 2'd0);
  assign result_pop     = m_result_valid & m_result_ready;
  assign feedback_d     = (result_occ_next != 2'd0);
  assign err_overflow_d = err_overflow | result_drop;

  result_skid_fifo #(
    .WIDTH(RESULT_PAIR_WIDTH)
  ) u_result_fifo (
    .clk            (aclk),
    .rst_n          (aresetn),
    .push           (result_push),
    .push_data      (pipe_result),
    .pop            (result_pop),
    .pop_data       (m_result_data),
    .occupancy      (result_occ),
    .occupancy_next (result_occ_next),
    .dropped        (result_drop)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q              <= StIdle;
      win_len_q            <= '0;
      win_cnt_q            <= '0;
      load_cnt_q           <= '0;
      drain_cnt_q          <= '0;
      pipe_result_feedback <= 1'b0;
      err_overflow         <= 1'b0;
    end else begin
      state_q              <= state_d;
      win_len_q            <= win_len_d;
      win_cnt_q            <= win_cnt_d;
      load_cnt_q           <= load_cnt_d;
      drain_cnt_q          <= drain_cnt_d;
      pipe_result_feedback <= feedback_d;
      err_overflow         <= err_overflow_d;
    end
  end

endmodule

// File: doc/join_pipeline_scheduler.md
# join_pipeline_scheduler

Sequencing controller for the stream-R join pipeline (chain of join core stages). It loads a batch of up to `STAGE_NUMS` stream tuples into the pipeline and streams a programmed number of window tuples through them. It then drains the pipeline, issues the clear, and returns to idle. It also converts the pipeline's result output and result back-pressure into a valid/ready result stream. It sits between the kernel's input/output FIFOs and the join pipeline.

## Interface
- `WINDOW_TUPLE_WIDTH`, `PARA_WINDOW_TUPLE_WIDTH`, window tuple width; MSB is the valid flag.
- `STREAM_TUPLE_WIDTH`, `PARA_STREAM_TUPLE_WIDTH`, stream tuple width; MSB is the valid flag.
- `RESULT_PAIR_WIDTH`, `PARA_RESULT_PAIR_WIDTH`, result width; MSB is the valid flag.
- `STAGE_NUMS`, `PARA_PIPELINE_STAGE_NUMS`, pipeline depth.
- `WLEN_WIDTH`, 32, window length counter width.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset; **one clock; reset is synchronous and active-low**.
- `start`  in  1  one-cycle pulse; honoured in IDLE only.
- `window_len`  in  WLEN_WIDTH  number of window tuples per batch; latched on `start`.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse at batch end.
- `s_stream_valid` / `s_stream_ready` / `s_stream_last`  in/out/in  1  stream tuple source handshake.
- `s_stream_data`  in  STREAM_TUPLE_WIDTH  stream tuple.
- `s_window_valid` / `s_window_ready`  in/out  1  window tuple source handshake.
- `s_window_data`  in  WINDOW_TUPLE_WIDTH  window tuple.
- `pipe_stream_full`  in  1  pipeline `stream_stage_full_output`; low means the head samples a stream tuple this cycle.
- `pipe_stream_clear`  out  1  to pipeline `stream_stage_clear_input`.
- `pipe_stream_tuple`  out  STREAM_TUPLE_WIDTH  to pipeline stream input.
- `pipe_window_full`  in  1  pipeline `window_stage_full_output`.
- `pipe_window_tuple`  out  WINDOW_TUPLE_WIDTH  to pipeline window input.
- `pipe_result`  in  RESULT_PAIR_WIDTH  pipeline tail result.
- `pipe_result_feedback`  out  1  to pipeline `result_stage_feedback_input`; high pauses the pipeline.
- `m_result_valid` / `m_result_ready`  out/in  1  result sink handshake.
- `m_result_data`  out  RESULT_PAIR_WIDTH  result pair.
- `err_overflow`  out  1  sticky; a result arrived while the skid buffer was full.

## Operation
- **FSM states:** IDLE, LOAD, PROBE, DRAIN, CLEAR, WAIT_EMPTY.
- **IDLE:** on `start`, latch `window_len`, zero the counters, go to LOAD.
- **LOAD:**
  - `s_stream_ready = ~pipe_stream_full`; on handshake, `pipe_stream_tuple = s_stream_data` and `load_cnt++`.
  - Otherwise `pipe_stream_tuple = 0` (bubble).
  - Go to PROBE after a handshake that makes `load_cnt == STAGE_NUMS` or carries `s_stream_last`.
- **PROBE:**
  - `s_window_ready = ~pipe_window_full & ~pipe_result_feedback`; on handshake, forward the data and `win_cnt++`.
  - Otherwise drive a zero bubble.
  - Go to DRAIN when `win_cnt == window_len`. `window_len == 0` goes to DRAIN immediately without sending anything.
- **DRAIN:** `drain_cnt` counts up to `2*STAGE_NUMS` and only advances while `pipe_result_feedback == 0`; then go to CLEAR.
- **CLEAR:** `pipe_stream_clear = 1` for exactly one cycle, then go to WAIT_EMPTY.
- **WAIT_EMPTY:** when `pipe_stream_full == 0`, pulse `done` and go to IDLE.
- **Result path:**
  - Two-entry skid FIFO. A push occurs when `pipe_result[MSB]` is set; the payload is stored as-is.
  - `m_result_valid` = FIFO non-empty; a pop occurs on `m_result_valid & m_result_ready`.
  - `pipe_result_feedback` is a register loaded with (next occupancy != 0 and not popping down to zero).
  - The result path runs in every state, including IDLE.
  - A push into a full FIFO drops the result and sets `err_overflow`.
- `s_stream_ready` and `s_window_ready` are 0 outside LOAD and PROBE respectively.

## Timing
- **Reset values:** all outputs are 0; FSM is IDLE; counters, FIFO and `err_overflow` are cleared.
- **Reset mid-batch:** same reset values; the pipeline is not cleared by reset. Software issues a new batch, whose CLEAR flushes any residue.
- **Pipeline outputs:** `pipe_*_tuple` and `pipe_stream_clear` are combinational from the state and handshake, so the pipeline samples in the handshake cycle.
- **Stream load:** one stream tuple per cycle while the head is open.
- **Window probe:** one window tuple per cycle unless the head is full or the pipeline is paused.
- **Result latency:** a result is visible on `m_result_*` one cycle after it appears on `pipe_result`. Push and pop in the same cycle keep the occupancy unchanged.
- **Feedback:** `pipe_result_feedback` rises the cycle after the first unpopped push and falls the cycle after the FIFO empties.
- **`start` while busy:** ignored.
- **`s_stream_last` on the first tuple:** loads a single-tuple batch.

## Structure
- The shared package `join_pkg` holds the FSM state encoding, the valid-flag index helpers and `DRAIN_CYCLES = 2*STAGE_NUMS`. Widths still come from the `para.v` macros.
- The skid FIFO is a sub-module, `result_skid_fifo` (depth 2, occupancy output).

## Test plan
- **Full load:** `STAGE_NUMS=4`, 4 stream tuples, `window_len=8`, sink always ready, `pipe_stream_full` low until 4 tuples are loaded -> 4 LOAD handshakes, 8 PROBE handshakes, DRAIN of 8 cycles, one clear pulse, `done` once.
- **Short batch:** `s_stream_last` on the 2nd tuple, `window_len=0` -> PROBE sends nothing; clear, then `done`; `load_cnt=2`.
- **Back-pressure:** `m_result_ready=0` for 10 cycles during PROBE with results arriving -> feedback high the cycle after the first push; `s_window_ready=0`; `drain_cnt` frozen; `err_overflow` stays 0; results are delivered in order once ready returns.
- **Head full:** `pipe_window_full=1` for 3 cycles mid-PROBE -> zero bubbles on `pipe_window_tuple`; `win_cnt` holds.
- **Reset mid-PROBE:** `aresetn=0` for 1 cycle -> all outputs 0 the next cycle; FSM in IDLE; a following `start` runs a normal batch.
- **Spurious start:** `start` pulsed during DRAIN -> ignored; `window_len` latch unchanged.
